fifo_write_arbiter: RTL and testbench
=====================================

# fifo_write_arbiter

Round-robin write arbiter that shares one synchronous FIFO write port among `N_REQ` producers. Each producer gets a valid/ready channel. A granted producer keeps the port for a bounded burst, then ownership rotates. The block sits directly in front of the sync FIFO buffer and drives its `write_i`/`wr_data_i` from its `full_o`. It guarantees the FIFO never sees a write while full.

## Interface
- `N_REQ`, 4: number of requesters (2..16).
- `DATA_WIDTH`, 32: word width; must match the FIFO.
- `MAX_BURST`, 4: maximum accepted beats per grant before rotation (1..255).
- `clk_i`  in  1  single clock, all state on rising edge.
- `rst_n_i`  in  1  asynchronous, active-low reset.
- `req_valid_i`  in  N_REQ  per-requester word valid.
- `req_data_i`  in  N_REQ*DATA_WIDTH  per-requester word; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `req_ready_o`  out  N_REQ  per-requester accept; at most one bit high.
- `fifo_full_i`  in  1  FIFO `full_o`.
- `fifo_write_o`  out  1  FIFO `write_i`.
- `fifo_wr_data_o`  out  DATA_WIDTH  FIFO `wr_data_i`.
- `grant_o`  out  N_REQ  one-hot current owner; all zero in IDLE.
- `busy_o`  out  1  high in GRANT.

## Operation
- State is IDLE or GRANT.
- Registers:
  - `owner`, $clog2(N_REQ) bits.
  - `rr_ptr`, the search start index.
  - `beat_cnt`, $clog2(MAX_BURST+1) bits.
- Winner selection is find-first valid requester, searching circularly from `rr_ptr`.
- IDLE:
  - If any `req_valid_i` is high: register winner into `owner`, clear `beat_cnt`, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT: `req_ready_o[owner] = !fifo_full_i`; all other ready bits are 0.
- A transfer occurs when `req_valid_i[owner] & req_ready_o[owner]`.
  - `fifo_write_o` = transfer.
  - `fifo_wr_data_o` = `req_data_i[owner]`; it is driven with the owner's word whenever in GRANT and is 0 in IDLE.
- Release in GRANT happens when either:
  - (a) a transfer brings `beat_cnt+1 == MAX_BURST`, or
  - (b) `req_valid_i[owner]` is low in that cycle.
- On release:
  - `rr_ptr` ← owner+1, wrapping at N_REQ.
  - Search from owner+1, over current valids, excluding the owner for case (a).
  - If a winner is found: stay in GRANT with the new owner and clear `beat_cnt` (direct handoff, no idle cycle).
  - If no winner is found: go to IDLE.
- Case (a) with only the owner valid: the owner is re-granted for a new burst, with `beat_cnt` cleared.
- Full stall: while `fifo_full_i` is high, no transfer occurs and `beat_cnt` holds. The grant is held indefinitely (no timeout). A stalled owner with valid high is not released.
- Requester rules (checked by assertion):
  - Once valid is high, it and the data stay stable until accepted.
  - Valid may drop only after a transfer.
- `req_ready_o` never depends on `req_valid_i`, so there is no combinational loop.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, `owner`=0, `rr_ptr`=0, `beat_cnt`=0.
  - All outputs 0, including all `req_ready_o` bits, `fifo_write_o`, `fifo_wr_data_o`, `grant_o`, `busy_o`.
  - A reset in the middle of a burst drops ownership; no partial write is issued after reset asserts.
- Arbitration latency:
  - Valid seen in IDLE at cycle t → GRANT at t+1 → first transfer at t+1 if not full.
  - Handoff between owners costs zero cycles.
- Throughput: one word per cycle while not full.
- `fifo_write_o` is combinational from `fifo_full_i`. The FIFO's registered `full_o` therefore blocks a write in the same cycle it is high.
- `grant_o` and `busy_o` are decoded from registered state only.

## Structure
- Package `fifo_arb_pkg`:
  - `arb_state_t` enum {IDLE, GRANT}.
  - Helper function `onehot(idx)`.
- Sub-module `rr_priority_picker`: purely combinational.
  - Inputs: request vector, start index, exclude mask.
  - Outputs: `found` flag and winner index.
  - Implementation: rotate, find-first, un-rotate.
- Top level holds the FSM, counters, and the data mux.

## Test plan
- Single requester 0 streams 10 words; N_REQ=4, MAX_BURST=4, FIFO never full → request seen cycle 0, grant cycle 1, 10 writes over cycles 1-12 with two 1-cycle re-grant gaps? No: re-grant is direct, so 10 consecutive writes in cycles 1-10, all data in order.
- All 4 requesters valid continuously → grant order 0,1,2,3,0…, each burst exactly 4 beats, with `fifo_write_o` high every cycle.
- Requester 2 owns the port; `fifo_full_i` held high 5 cycles mid-burst → no `fifo_write_o`, `beat_cnt` frozen, same owner resumes, burst totals 4 beats.
- Owner 1 drops valid after 2 beats while 3 is valid → next cycle `grant_o`=4'b1000; `rr_ptr`=2.
- `rst_n_i` pulsed low mid-burst → all outputs 0 immediately; after release, requester 0 wins first.
- Random valids/full over 10k cycles → scoreboard matches the FIFO write stream to per-requester order, with no write while full and no requester starved beyond (N_REQ-1)*MAX_BURST accepted beats.

Source files
------------

// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int MAX_REQ   = 16;
  localparam int IDX_MAX_W = 4;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  function automatic logic [MAX_REQ-1:0] onehot(input logic [IDX_MAX_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_picker.sv
// Combinational round-robin picker: first set request at or after start, circularly.
module rr_priority_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] start,
  input  logic [N_REQ-1:0] exclude,
  output logic             found,
  output logic [IDX_W-1:0] winner
);

  logic [N_REQ-1:0] masked;
  logic [N_REQ-1:0] rotated;
  logic [IDX_W-1:0] offset;
  logic [IDX_W:0]   sum;

  assign masked  = req & ~exclude;
  // Bit 0 of rotated corresponds to requester 'start'.
  assign rotated = N_REQ'({masked, masked} >> start);

  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        found  = 1'b1;
        offset = IDX_W'(i);
      end
    end
  end

  assign sum    = {1'b0, start} + {1'b0, offset};
  assign winner = (sum >= (IDX_W+1)'(N_REQ)) ? IDX_W'(sum - (IDX_W+1)'(N_REQ))
                                             : sum[IDX_W-1:0];

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one sync FIFO write port among N_REQ producers.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic [N_REQ-1:0]            req_valid_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [N_REQ-1:0]            req_ready_o,
  input  logic                        fifo_full_i,
  output logic                        fifo_write_o,
  output logic [DATA_WIDTH-1:0]       fifo_wr_data_o,
  output logic [N_REQ-1:0]            grant_o,
  output logic                        busy_o
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t       state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] rr_ptr;
  logic [CNT_W-1:0] beat_cnt;

  logic [DATA_WIDTH-1:0] words [N_REQ];
  logic [N_REQ-1:0]      own_mask;
  logic [IDX_W-1:0]      owner_inc;
  logic [IDX_W-1:0]      pick_start;
  logic [N_REQ-1:0]      pick_excl;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_found;
  logic [CNT_W-1:0]      cnt_inc;
  logic                  in_grant;
  logic                  owner_valid;
  logic                  transfer;
  logic                  burst_done;
  logic                  release_idle;

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign words[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  assign in_grant     = (state == GRANT);
  assign own_mask     = N_REQ'(onehot(IDX_MAX_W'(owner)));
  assign owner_valid  = req_valid_i[owner];
  assign transfer     = in_grant & owner_valid & ~fifo_full_i;
  assign cnt_inc      = beat_cnt + 1'b1;
  assign burst_done   = transfer && (cnt_inc == CNT_W'(MAX_BURST));
  assign release_idle = in_grant & ~owner_valid;
  assign owner_inc    = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;

  // On a completed burst the owner steps aside; it only keeps the port if nobody else wants it.
  assign pick_start = in_grant ? owner_inc : rr_ptr;
  assign pick_excl  = burst_done ? own_mask : '0;

  rr_priority_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req     (req_valid_i),
    .start   (pick_start),
    .exclude (pick_excl),
    .found   (pick_found),
    .winner  (pick_idx)
  );

  assign req_ready_o    = (in_grant && !fifo_full_i) ? own_mask : '0;
  assign grant_o        = in_grant ? own_mask : '0;
  assign busy_o         = in_grant;
  assign fifo_write_o   = transfer;
  assign fifo_wr_data_o = in_grant ? words[owner] : '0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            owner    <= pick_idx;
            beat_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (burst_done || release_idle) begin
            rr_ptr   <= owner_inc;
            beat_cnt <= '0;
            if (pick_found) begin
              owner <= pick_idx;
            end else if (!burst_done) begin
              state <= IDLE;
            end
          end else if (transfer) begin
            beat_cnt <= cnt_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Producer protocol: a pending word keeps valid high and its data stable until accepted.
  logic [N_REQ-1:0]      pending;
  logic [DATA_WIDTH-1:0] held [N_REQ];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pending <= '0;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        if (pending[k]) begin
          assert (req_valid_i[k]);
          assert (words[k] == held[k]);
        end
      end
      pending <= req_valid_i & ~req_ready_o;
    end
  end

  always_ff @(posedge clk_i) begin
    held <= words;
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: streaming, rotation, full stall, handoff and reset.
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   valid;
  logic [W-1:0]   d [N];
  logic [N*W-1:0] req_data;
  logic [N-1:0]   ready;
  logic           full;
  logic           write;
  logic [W-1:0]   wdata;
  logic [N-1:0]   grant;
  logic           busy;

  int total = 0;
  int bad   = 0;
  int seq [N];
  int n;
  int cnt2;
  int o;

  always #5 clk = ~clk;

  assign req_data = {d[3], d[2], d[1], d[0]};

  fifo_write_arbiter #(
    .N_REQ      (N),
    .DATA_WIDTH (W),
    .MAX_BURST  (MB)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .req_valid_i    (valid),
    .req_data_i     (req_data),
    .req_ready_o    (ready),
    .fifo_full_i    (full),
    .fifo_write_o   (write),
    .fifo_wr_data_o (wdata),
    .grant_o        (grant),
    .busy_o         (busy)
  );

  function automatic logic [31:0] word(input int k, input int s);
    return 32'hA000_0000 + 32'(k) * 32'h0001_0000 + 32'(s);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = '0;
    full  = 1'b0;
    for (int k = 0; k < N; k++) begin
      d[k]   = '0;
      seq[k] = 0;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // Reset values
    #1;
    check("rst_ready", 32'(ready), 0);
    check("rst_write", 32'(write), 0);
    check("rst_data",  wdata, 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_busy",  32'(busy), 0);
    @(negedge clk);

    // Single requester streams 10 words back to back across re-grants
    n = 0;
    for (int c = 0; c <= 11; c++) begin
      valid = (n < 10) ? 4'b0001 : 4'b0000;
      d[0]  = word(0, n);
      #1;
      if (c == 0) begin
        check("t1_idle_write", 32'(write), 0);
        check("t1_idle_busy",  32'(busy), 0);
      end else if (c <= 10) begin
        check("t1_write", 32'(write), 1);
        check("t1_data",  wdata, word(0, n));
        check("t1_grant", 32'(grant), 32'h1);
        n++;
      end else begin
        check("t1_tail_busy",  32'(busy), 1);
        check("t1_tail_write", 32'(write), 0);
      end
      @(negedge clk);
    end
    #1;
    check("t1_back_idle", 32'(busy), 0);

    // All requesters valid: 0,1,2,3,0 rotation, 4 beats each, write every cycle
    do_reset();
    for (int c = 0; c <= 16; c++) begin
      valid = 4'hF;
      for (int k = 0; k < N; k++) d[k] = word(k, seq[k]);
      #1;
      if (c == 0) begin
        check("t2_idle_write", 32'(write), 0);
      end else begin
        o = ((c - 1) / MB) % N;
        check("t2_grant", 32'(grant), 32'(1 << o));
        check("t2_ready", 32'(ready), 32'(1 << o));
        check("t2_write", 32'(write), 1);
        check("t2_data",  wdata, word(o, seq[o]));
        seq[o]++;
      end
      @(negedge clk);
    end

    // Requester 2 stalled by full for 5 cycles mid-burst, then hands off to 0
    do_reset();
    cnt2 = 0;
    for (int c = 0; c <= 10; c++) begin
      valid    = '0;
      valid[2] = (seq[2] < MB);
      valid[0] = (c >= 3);
      full     = (c >= 3 && c <= 7);
      d[2]     = word(2, seq[2]);
      d[0]     = word(0, 0);
      #1;
      if (write && grant == 4'b0100) cnt2++;
      if (c == 0) begin
        check("t3_idle_write", 32'(write), 0);
      end else if (c == 1 || c == 2 || c == 8 || c == 9) begin
        check("t3_grant", 32'(grant), 32'h4);
        check("t3_write", 32'(write), 1);
        check("t3_data",  wdata, word(2, seq[2]));
        seq[2]++;
      end else if (c <= 7) begin
        check("t3_stall_write", 32'(write), 0);
        check("t3_stall_ready", 32'(ready), 0);
        check("t3_stall_grant", 32'(grant), 32'h4);
      end else begin
        check("t3_handoff_grant", 32'(grant), 32'h1);
        check("t3_handoff_write", 32'(write), 1);
        check("t3_handoff_data",  wdata, word(0, 0));
      end
      @(negedge clk);
    end
    check("t3_burst_beats", 32'(cnt2), MB);

    // Owner 1 drops valid after 2 beats; waiting requester 3 takes over with no gap
    do_reset();
    for (int c = 0; c <= 4; c++) begin
      valid    = '0;
      valid[1] = (c <= 2);
      valid[3] = (c >= 1);
      d[1]     = word(1, seq[1]);
      d[3]     = word(3, 0);
      #1;
      if (c == 1 || c == 2) begin
        check("t4_grant1", 32'(grant), 32'h2);
        check("t4_data1",  wdata, word(1, seq[1]));
        seq[1]++;
      end else if (c == 3) begin
        check("t4_drop_grant", 32'(grant), 32'h2);
        check("t4_drop_write", 32'(write), 0);
      end else if (c == 4) begin
        check("t4_grant3", 32'(grant), 32'h8);
        check("t4_write3", 32'(write), 1);
        check("t4_data3",  wdata, word(3, 0));
        check("t4_rr_ptr", 32'(dut.rr_ptr), 2);
      end
      @(negedge clk);
    end

    // Reset pulse in the middle of requester 3's burst
    valid = 4'b1000;
    d[3]  = word(3, 1);
    #1;
    check("t5_pre_write", 32'(write), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_write", 32'(write), 0);
    check("t5_rst_ready", 32'(ready), 0);
    check("t5_rst_grant", 32'(grant), 0);
    check("t5_rst_busy",  32'(busy), 0);
    check("t5_rst_data",  wdata, 0);
    @(negedge clk);
    valid = 4'b1001;
    d[0]  = word(0, 0);
    rst_n = 1'b1;
    #1;
    check("t5_post_busy", 32'(busy), 0);
    @(negedge clk);
    #1;
    check("t5_post_grant", 32'(grant), 32'h1);
    check("t5_post_write", 32'(write), 1);
    check("t5_post_data",  wdata, word(0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
